// File: rtl/formula_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : formula_pipe_pkg
//  Description : Shared defaults, result type and sizing helper for the
//                formula_1 pipeline result buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package formula_pipe_pkg;

    localparam int unsigned C_WIDTH = 32;
    localparam int unsigned C_DEPTH = 8;

    typedef logic [C_WIDTH-1:0] result_t;

    // Width of a counter that must hold every value 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/formula_1_result_buffer_flop_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : flop_fifo
//  Description : Flop-based synchronous FIFO. Pointers and occupancy count are
//                async-reset; the storage array is not reset and is written
//                only on an accepted push.
//  Revision    : 1.0 - initial release
// ============================================================================
module flop_fifo
    import formula_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = C_WIDTH,
    parameter int unsigned DEPTH = C_DEPTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push,
    input  logic                            pop,
    input  logic [WIDTH-1:0]                din,
    output logic [WIDTH-1:0]                dout,
    output logic                            full,
    output logic                            empty,
    output logic [cnt_width(DEPTH)-1:0]     count
);

    localparam int unsigned C_CNT_W = cnt_width(DEPTH);
    localparam int unsigned C_PTR_W = $clog2(DEPTH);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE = C_CNT_W'(1);
    localparam logic [C_PTR_W-1:0] C_PTR_ONE = C_PTR_W'(1);
    localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [C_PTR_W-1:0] r_wr_ptr;
    logic [C_PTR_W-1:0] r_rd_ptr;
    logic [C_CNT_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full  = (r_count == C_CNT_MAX);
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    // A push into a full FIFO is only accepted when a pop frees the slot in
    // the same cycle; a pop from an empty FIFO is ignored.
    assign w_do_push = push & (~full | pop);
    assign w_do_pop  = pop & ~empty;

    // Storage: written only on an accepted push, never reset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Write pointer advances on each accepted push, wrapping at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
        end else if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
        end
    end

    // Read pointer advances on each accepted pop, wrapping at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
        end else if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
        end
    end

    // Occupancy changes only when exactly one of push/pop happens.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_do_push & ~w_do_pop) begin
            r_count <= r_count + C_CNT_ONE;
        end else if (w_do_pop & ~w_do_push) begin
            r_count <= r_count - C_CNT_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/formula_1_result_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : formula_1_result_buffer
//  Description : Elastic valid/ready wrapper around a fixed-latency,
//                non-stallable pipe. Arguments are issued only against a
//                credit, so every result the pipe returns already owns a
//                FIFO slot. Results are held until the consumer takes them.
//  Revision    : 1.0 - initial release
// ============================================================================
module formula_1_result_buffer
    import formula_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = C_WIDTH,
    parameter int unsigned DEPTH = C_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    // upstream argument interface
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    // pipe issue side
    output logic             pipe_arg_vld,
    output logic [WIDTH-1:0] pipe_a,
    output logic [WIDTH-1:0] pipe_b,
    output logic [WIDTH-1:0] pipe_c,
    // pipe result side
    input  logic             pipe_res_vld,
    input  logic [WIDTH-1:0] pipe_res,
    // downstream result interface
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_data,
    // sticky protocol error
    output logic             err
);

    localparam int unsigned        C_CNT_W   = cnt_width(DEPTH);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE = C_CNT_W'(1);
    localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(DEPTH);

    logic [C_CNT_W-1:0] r_credits;
    logic [C_CNT_W-1:0] r_outstanding;
    logic               r_err;
    logic               w_issue;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [C_CNT_W-1:0] w_fifo_count;

    // in_rdy comes straight from the credit register so there is no
    // combinational path from out_rdy back to the upstream side.
    assign in_rdy       = (r_credits != '0);
    assign w_issue      = in_vld & in_rdy;

    assign pipe_arg_vld = w_issue;
    assign pipe_a       = a;
    assign pipe_b       = b;
    assign pipe_c       = c;

    assign out_vld      = (w_fifo_count != '0);
    assign w_pop        = out_rdy & ~w_fifo_empty;

    // A result is illegal if nothing was issued for it, or if it would land
    // in a full FIFO that is not draining this cycle. Illegal results are
    // discarded without touching any state except the error flag.
    assign w_drop       = pipe_res_vld & ((r_outstanding == '0) | (w_fifo_full & ~w_pop));
    assign w_push       = pipe_res_vld & ~w_drop;

    assign err          = r_err;

    flop_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (pipe_res),
        .dout  (out_data),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    // Credits: taken on issue, returned on pop; simultaneous events cancel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credits <= C_CNT_MAX;
        end else if (w_issue & ~w_pop) begin
            r_credits <= r_credits - C_CNT_ONE;
        end else if (w_pop & ~w_issue) begin
            r_credits <= r_credits + C_CNT_ONE;
        end
    end

    // Outstanding: results in flight inside the pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outstanding <= '0;
        end else if (w_issue & ~w_push) begin
            r_outstanding <= r_outstanding + C_CNT_ONE;
        end else if (w_push & ~w_issue) begin
            r_outstanding <= r_outstanding - C_CNT_ONE;
        end
    end

    // Error flag sets on any dropped result and holds until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_drop) begin
            r_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_formula_1_result_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_formula_1_result_buffer
//  Description : Scoreboard bench for formula_1_result_buffer with a
//                behavioural fixed-latency pipe (isqrt(a) + b - c).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_formula_1_result_buffer;
    import formula_pipe_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int L     = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_vld, in_rdy;
    logic [WIDTH-1:0] a, b, c;
    logic             pipe_arg_vld;
    logic [WIDTH-1:0] pipe_a, pipe_b, pipe_c;
    logic             pipe_res_vld;
    logic [WIDTH-1:0] pipe_res;
    logic             out_vld, out_rdy;
    logic [WIDTH-1:0] out_data;
    logic             err;
    logic             force_res_vld;

    int n_vec  = 0;
    int n_miss = 0;
    int n_pop  = 0;
    result_t sb[$];

    always #5 clk = ~clk;

    formula_1_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_rdy(in_rdy), .a(a), .b(b), .c(c),
        .pipe_arg_vld(pipe_arg_vld), .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_c(pipe_c),
        .pipe_res_vld(pipe_res_vld), .pipe_res(pipe_res),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .err(err)
    );

    function automatic logic [31:0] isqrt(input logic [31:0] v);
        logic [31:0] r;
        logic [31:0] t;
        r = 0;
        for (int i = 15; i >= 0; i--) begin
            t = r | (32'd1 << i);
            if (64'(t) * 64'(t) <= 64'(v)) r = t;
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_fn(input logic [31:0] x, input logic [31:0] y,
                                           input logic [31:0] z);
        return isqrt(x) + y - z;
    endfunction

    // Behavioural pipe: L-stage, non-stallable, shares rst with the buffer.
    logic [L-1:0]     p_vld;
    logic [WIDTH-1:0] p_a [L];
    logic [WIDTH-1:0] p_b [L];
    logic [WIDTH-1:0] p_c [L];

    always @(posedge clk or posedge rst) begin
        if (rst) p_vld <= '0;
        else     p_vld <= {p_vld[L-2:0], pipe_arg_vld};
    end

    always @(posedge clk) begin
        p_a[0] <= pipe_a;
        p_b[0] <= pipe_b;
        p_c[0] <= pipe_c;
        for (int i = 1; i < L; i++) begin
            p_a[i] <= p_a[i-1];
            p_b[i] <= p_b[i-1];
            p_c[i] <= p_c[i-1];
        end
    end

    assign pipe_res_vld = p_vld[L-1] | force_res_vld;
    assign pipe_res     = ref_fn(p_a[L-1], p_b[L-1], p_c[L-1]);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pop/compare on each consumed result, push expectation on issue.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (out_vld && out_rdy) begin
                n_pop++;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_result: got %0d expected none", out_data);
                end else begin
                    chk("result_data", 64'(out_data), 64'(sb.pop_front()));
                end
            end
            if (pipe_arg_vld) sb.push_back(ref_fn(a, b, c));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_args();
        a = $urandom;
        b = $urandom;
        c = $urandom;
    endtask

    task automatic drain();
        int k;
        out_rdy = 1'b1;
        repeat (L + 2) step();
        k = 0;
        while (out_vld && k < 100) begin
            step();
            k++;
        end
        if (out_vld) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain_timeout: got out_vld=1 expected 0");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int acc;
        int kk;
        int seen;

        // 1. reset with in_vld held high
        rst = 1'b1; in_vld = 1'b1; out_rdy = 1'b1; force_res_vld = 1'b0;
        a = 0; b = 0; c = 0;
        #1;
        chk("rst_out_vld", out_vld, 0);
        chk("rst_in_rdy", in_rdy, 1);
        chk("rst_err", err, 0);
        repeat (3) step();
        in_vld = 1'b0;
        rst    = 1'b0;
        seen   = 0;
        repeat (L + 4) begin
            step();
            if (out_vld) seen++;
        end
        chk("no_result_after_rst", seen, 0);

        // 2. single transaction latency and value
        a = 16; b = 9; c = 4; in_vld = 1'b1; out_rdy = 1'b1;
        step();
        in_vld = 1'b0;
        lat = 1;
        while (!out_vld && lat < 30) begin
            step();
            lat++;
        end
        chk("single_latency", lat, L + 1);
        chk("single_data", out_data, 9);
        step();
        chk("single_one_cycle", out_vld, 0);

        // 3. fill with consumer stalled
        out_rdy = 1'b0;
        kk  = 1;
        acc = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            a = 32'(kk * kk);
            b = $urandom_range(0, 100);
            c = $urandom_range(0, 100);
            in_vld = 1'b1;
            @(negedge clk);
            if (in_rdy) begin
                acc++;
                kk++;
            end
            step();
        end
        in_vld = 1'b0;
        chk("fill_accepts", acc, DEPTH);
        chk("fill_in_rdy", in_rdy, 0);
        chk("fill_err", err, 0);
        repeat (L + 2) step();
        chk("fill_out_vld", out_vld, 1);
        out_rdy = 1'b1;
        @(negedge clk);
        chk("pop_cycle_in_rdy", in_rdy, 0);
        step();
        chk("after_pop_in_rdy", in_rdy, 1);
        drain();
        chk("fill_sb_empty", sb.size(), 0);

        // 4. full-rate streaming
        n_pop   = 0;
        in_vld  = 1'b1;
        out_rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            rand_args();
            @(negedge clk);
            chk("stream_in_rdy", in_rdy, 1);
            step();
        end
        in_vld = 1'b0;
        drain();
        chk("stream_count", n_pop, 200);
        chk("stream_sb_empty", sb.size(), 0);

        // 5. zero credits, FIFO full, single-cycle pop
        out_rdy = 1'b0;
        in_vld  = 1'b1;
        kk = 0;
        rand_args();
        @(negedge clk);
        while (in_rdy && kk < 20) begin
            step();
            rand_args();
            kk++;
            @(negedge clk);
        end
        step();
        in_vld = 1'b0;
        chk("credit_fill_count", kk, DEPTH);
        repeat (L + 2) step();
        n_pop   = 0;
        rand_args();
        in_vld  = 1'b1;
        out_rdy = 1'b1;
        @(negedge clk);
        chk("full_no_credit", in_rdy, 0);
        step();
        out_rdy = 1'b0;
        @(negedge clk);
        chk("credit_returned", in_rdy, 1);
        step();
        in_vld = 1'b0;
        @(negedge clk);
        chk("credit_consumed", in_rdy, 0);
        step();
        repeat (L + 2) step();
        chk("full_out_vld", out_vld, 1);
        drain();
        chk("full_pop_total", n_pop, DEPTH + 1);
        chk("full_sb_empty", sb.size(), 0);

        // 6. spurious pipe result, then async reset mid-stream
        out_rdy = 1'b0;
        force_res_vld = 1'b1;
        step();
        force_res_vld = 1'b0;
        @(negedge clk);
        chk("spurious_err", err, 1);
        chk("spurious_no_write", out_vld, 0);
        repeat (3) step();
        chk("err_sticky", err, 1);
        in_vld = 1'b1;
        repeat (L + 1) begin
            rand_args();
            step();
        end
        in_vld = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_in_rdy", in_rdy, 1);
        chk("async_rst_out_vld", out_vld, 0);
        chk("async_rst_err", err, 0);
        repeat (2) step();
        rst  = 1'b0;
        seen = 0;
        repeat (L + 3) begin
            step();
            if (out_vld) seen++;
        end
        chk("post_rst_no_result", seen, 0);
        n_pop = 0;
        a = 100; b = 5; c = 3; in_vld = 1'b1; out_rdy = 1'b1;
        step();
        in_vld = 1'b0;
        drain();
        chk("post_rst_pop", n_pop, 1);
        chk("post_rst_err", err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
